// File: rtl/fifo_flex.sv
// Single-clock FIFO with occupancy count, programmable almost flags, error pulses
// and a selectable standard (registered) or first-word-fall-through read port.
module fifo_flex #(
    parameter int DEPTH    = 64,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wa;
    logic             ra;
    logic [CW-1:0]    count_next;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write
    // alongside a read; a write never makes an empty FIFO readable.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_next = count;
        ra         = rd_en && !empty;
        wa         = wr_en && (!full || ra);
        if (wa && !ra)
            count_next = count + 1'b1;
        else if (ra && !wa)
            count_next = count - 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wa) wr_ptr <= wr_ptr + 1'b1;
            if (ra) rd_ptr <= rd_ptr + 1'b1;
            count        <= count_next;
            full         <= (count_next == DEPTH_CNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
            overflow     <= wr_en && !wa;
            underflow    <= rd_en && empty;
        end
    end

    // NOTE: storage has no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wa) mem[wr_ptr] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is driven straight from storage; zero while nothing is stored.
            assign rd_data = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [WIDTH-1:0] rd_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rd_q <= '0;
                else if (ra)
                    rd_q <= mem[rd_ptr];
            end
            assign rd_data = rd_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_flex.sv
// Randomized self-checking bench: a standard-read instance (DEPTH 64) and a FWFT
// instance (DEPTH 8) are compared cycle by cycle against queue-based models.
module tb_fifo_flex;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Standard-read instance
    logic       rst_n0 = 1'b0, wr_en0 = 1'b0, rd_en0 = 1'b0;
    logic [7:0] wr_data0 = '0, rd_data0;
    logic       full0, empty0, af0, ae0, ov0, un0;
    logic [6:0] count0;

    fifo_flex #(.DEPTH(64), .WIDTH(8), .AF_LEVEL(60), .AE_LEVEL(4), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n0), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
        .rd_data(rd_data0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ov0), .underflow(un0)
    );

    // FWFT instance
    logic       rst_n1 = 1'b0, wr_en1 = 1'b0, rd_en1 = 1'b0;
    logic [7:0] wr_data1 = '0, rd_data1;
    logic       full1, empty1, af1, ae1, ov1, un1;
    logic [3:0] count1;

    fifo_flex #(.DEPTH(8), .WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n1), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
        .rd_data(rd_data1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ov1), .underflow(un1)
    );

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp_rd0 = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the standard instance; model follows the accept rules directly.
    task automatic cycle0(input logic wr, input logic [7:0] d, input logic rd);
        bit was_full, was_empty, acc_rd, acc_wr;
        was_full  = (q0.size() == 64);
        was_empty = (q0.size() == 0);
        acc_rd    = rd && !was_empty;
        acc_wr    = wr && (!was_full || acc_rd);
        wr_en0 = wr; wr_data0 = d; rd_en0 = rd;
        @(posedge clk); #1;
        wr_en0 = 1'b0; rd_en0 = 1'b0;
        if (acc_rd) exp_rd0 = q0.pop_front();
        if (acc_wr) q0.push_back(d);
        check("std_count", count0, q0.size());
        check("std_full", full0, q0.size() == 64);
        check("std_empty", empty0, q0.size() == 0);
        check("std_af", af0, q0.size() >= 60);
        check("std_ae", ae0, q0.size() <= 4);
        check("std_overflow", ov0, wr && !acc_wr);
        check("std_underflow", un0, rd && was_empty);
        check("std_rd_data", rd_data0, exp_rd0);
    endtask

    task automatic cycle1(input logic wr, input logic [7:0] d, input logic rd);
        bit was_full, was_empty, acc_rd, acc_wr;
        was_full  = (q1.size() == 8);
        was_empty = (q1.size() == 0);
        acc_rd    = rd && !was_empty;
        acc_wr    = wr && (!was_full || acc_rd);
        wr_en1 = wr; wr_data1 = d; rd_en1 = rd;
        @(posedge clk); #1;
        wr_en1 = 1'b0; rd_en1 = 1'b0;
        if (acc_rd) void'(q1.pop_front());
        if (acc_wr) q1.push_back(d);
        check("fwft_count", count1, q1.size());
        check("fwft_full", full1, q1.size() == 8);
        check("fwft_empty", empty1, q1.size() == 0);
        check("fwft_af", af1, q1.size() >= 6);
        check("fwft_ae", ae1, q1.size() <= 1);
        check("fwft_overflow", ov1, wr && !acc_wr);
        check("fwft_underflow", un1, rd && was_empty);
        if (q1.size() != 0) check("fwft_head", rd_data1, q1[0]);
    endtask

    initial begin
        #13;
        check("rst_count", count0, 0);
        check("rst_empty", empty0, 1);
        check("rst_ae", ae0, 1);
        check("rst_full", full0, 0);
        check("rst_af", af0, 0);
        check("rst_ov", ov0, 0);
        check("rst_un", un0, 0);
        check("rst_rd_data", rd_data0, 0);
        check("rst_fwft_empty", empty1, 1);
        @(negedge clk);
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        @(posedge clk); #1;

        // Basics
        cycle0(1, 8'h11, 0); cycle0(1, 8'h22, 0); cycle0(1, 8'h33, 0);
        repeat (3) cycle0(0, 8'h00, 1);

        // Underflow, then write+read on empty
        cycle0(0, 8'h00, 1);
        cycle0(1, 8'hAA, 1);
        cycle0(0, 8'h00, 1);

        // Fill, overflow, simultaneous at full, drain
        for (int i = 0; i < 64; i++) cycle0(1, 8'(i), 0);
        cycle0(1, 8'hEE, 0);
        cycle0(0, 8'h00, 0);
        repeat (3) cycle0(1, 8'h55, 1);
        repeat (64) cycle0(0, 8'h00, 1);
        check("drain_empty", empty0, 1);

        // Random traffic with occupancy bounded to 1..10, crossing the pointer wrap
        cycle0(1, 8'($urandom), 0);
        for (int i = 0; i < 200; i++) begin
            logic w, r;
            w = (q0.size() < 10) ? 1'($urandom) : 1'b0;
            r = (q0.size() > 1)  ? 1'($urandom) : 1'b0;
            cycle0(w, 8'($urandom), r);
        end
        while (q0.size() != 0) cycle0(0, 8'h00, 1);

        // FWFT: head visible without a request
        cycle1(1, 8'h7E, 0);
        check("fwft_first_word", rd_data1, 8'h7E);
        cycle1(1, 8'h7F, 0);
        cycle1(0, 8'h00, 1);
        check("fwft_pop_next", rd_data1, 8'h7F);
        cycle1(0, 8'h00, 1);
        cycle1(0, 8'h00, 1);
        for (int i = 0; i < 60; i++) cycle1(1'($urandom), 8'($urandom), 1'($urandom));

        // Async reset mid-stream
        cycle1(1, 8'h01, 0); cycle1(1, 8'h02, 0);
        @(negedge clk);
        rst_n1 = 1'b0;
        #1;
        check("arst_empty", empty1, 1);
        check("arst_count", count1, 0);
        q1.delete();
        @(negedge clk);
        rst_n1 = 1'b1;
        cycle1(1, 8'h42, 0);
        check("post_rst_head", rd_data1, 8'h42);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
